// File: rtl/ringer_pkg.sv
// ---------------------------------------------------------------------------
// ringer_pkg
// Shared types and constants for the ringer cadence driver.
//   - FSM state encoding (localparams) and the enum built on it
//   - saturation ceiling for the 8-bit burst counter
//   - max4(): picks the widest duration so one counter fits every state
// ---------------------------------------------------------------------------
package ringer_pkg;

  localparam logic [2:0] ENC_IDLE     = 3'd0;
  localparam logic [2:0] ENC_RING_ON  = 3'd1;
  localparam logic [2:0] ENC_RING_OFF = 3'd2;
  localparam logic [2:0] ENC_BUZZ_ON  = 3'd3;
  localparam logic [2:0] ENC_BUZZ_OFF = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = ENC_IDLE,
    ST_RING_ON  = ENC_RING_ON,
    ST_RING_OFF = ENC_RING_OFF,
    ST_BUZZ_ON  = ENC_BUZZ_ON,
    ST_BUZZ_OFF = ENC_BUZZ_OFF
  } ringer_state_e;

  localparam logic [7:0] BURST_MAX = 8'hFF;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ringer_down_counter.sv
// ---------------------------------------------------------------------------
// ringer_down_counter
// Loadable down-counter that parks at zero.
//   clk      in  clock
//   reset    in  async active-high reset (count -> 0)
//   load     in  load load_val this cycle (has priority over en)
//   load_val in  W-bit reload value
//   en       in  decrement while non-zero
//   zero     out count == 0
// ---------------------------------------------------------------------------
module ringer_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/ringer_cadence_driver.sv
// ---------------------------------------------------------------------------
// ringer_cadence_driver
// Turns level ring / vibrate requests into a timed speaker / motor cadence.
//   clk            in   clock
//   reset          in   async active-high reset
//   turn_on_ringer in   ring request (wins over motor)
//   turn_on_motor  in   vibrate request
//   speaker        out  square-wave tone, only during RING_ON
//   motor          out  high in BUZZ_ON
//   active         out  high in any non-IDLE state
//   burst_count    out  ON-state entries since leaving IDLE, saturating
//
//   state    | meaning
//   IDLE     | no request, outputs quiet, burst_count held
//   RING_ON  | tone burst, RING_ON_CYCLES long
//   RING_OFF | silence between bursts, RING_OFF_CYCLES long
//   BUZZ_ON  | motor pulse, BUZZ_ON_CYCLES long
//   BUZZ_OFF | motor rest, BUZZ_OFF_CYCLES long
// ---------------------------------------------------------------------------
module ringer_cadence_driver
  import ringer_pkg::*;
#(
  parameter int RING_ON_CYCLES  = 8,
  parameter int RING_OFF_CYCLES = 16,
  parameter int BUZZ_ON_CYCLES  = 4,
  parameter int BUZZ_OFF_CYCLES = 4,
  parameter int TONE_HALF       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       turn_on_ringer,
  input  logic       turn_on_motor,
  output logic       speaker,
  output logic       motor,
  output logic       active,
  output logic [7:0] burst_count
);

  localparam int DUR_MAX = max4(RING_ON_CYCLES, RING_OFF_CYCLES,
                                BUZZ_ON_CYCLES, BUZZ_OFF_CYCLES);
  localparam int DUR_W   = $clog2(DUR_MAX) + 1;
  localparam int TONE_W  = $clog2(TONE_HALF) + 1;

  ringer_state_e r_state;
  ringer_state_e w_state_next;
  logic          r_speaker;
  logic [7:0]    r_burst;

  logic              w_ring;
  logic              w_buzz;
  logic              w_in_ring;
  logic              w_in_buzz;
  logic              w_enter;
  logic              w_dur_zero;
  logic [DUR_W-1:0]  w_dur_load_val;
  logic              w_tone_zero;
  logic              w_tone_load;
  logic              w_speaker_next;
  logic [7:0]        w_burst_next;

  assign w_ring    = turn_on_ringer;
  assign w_buzz    = turn_on_motor & ~turn_on_ringer;
  assign w_in_ring = (r_state == ST_RING_ON) || (r_state == ST_RING_OFF);
  assign w_in_buzz = (r_state == ST_BUZZ_ON) || (r_state == ST_BUZZ_OFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Timed transitions first, then request checks override them.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RING_ON:  if (w_dur_zero) w_state_next = ST_RING_OFF;
      ST_RING_OFF: if (w_dur_zero) w_state_next = ST_RING_ON;
      ST_BUZZ_ON:  if (w_dur_zero) w_state_next = ST_BUZZ_OFF;
      ST_BUZZ_OFF: if (w_dur_zero) w_state_next = ST_BUZZ_ON;
      default:     w_state_next = r_state;
    endcase
    if (!w_ring && !w_buzz) begin
      w_state_next = ST_IDLE;
    end else if (w_ring && !w_in_ring) begin
      w_state_next = ST_RING_ON;
    end else if (w_buzz && !w_in_buzz) begin
      w_state_next = ST_BUZZ_ON;
    end
  end

  // No state ever re-enters itself, so any change of state is an entry.
  assign w_enter = (w_state_next != r_state);

  always_comb begin
    w_dur_load_val = '0;
    case (w_state_next)
      ST_RING_ON:  w_dur_load_val = DUR_W'(RING_ON_CYCLES - 1);
      ST_RING_OFF: w_dur_load_val = DUR_W'(RING_OFF_CYCLES - 1);
      ST_BUZZ_ON:  w_dur_load_val = DUR_W'(BUZZ_ON_CYCLES - 1);
      ST_BUZZ_OFF: w_dur_load_val = DUR_W'(BUZZ_OFF_CYCLES - 1);
      default:     w_dur_load_val = '0;
    endcase
  end

  ringer_down_counter #(.W(DUR_W)) u_dur_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_enter),
    .load_val (w_dur_load_val),
    .en       (1'b1),
    .zero     (w_dur_zero)
  );

  // Tone counter reloads on RING_ON entry and at every speaker toggle.
  assign w_tone_load = (w_state_next == ST_RING_ON) &&
                       (w_enter || w_tone_zero);

  ringer_down_counter #(.W(TONE_W)) u_tone_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_tone_load),
    .load_val (TONE_W'(TONE_HALF - 1)),
    .en       (r_state == ST_RING_ON),
    .zero     (w_tone_zero)
  );

  always_comb begin
    w_speaker_next = 1'b0;
    if (w_state_next == ST_RING_ON) begin
      if (w_enter) begin
        w_speaker_next = 1'b1;
      end else if (w_tone_zero) begin
        w_speaker_next = ~r_speaker;
      end else begin
        w_speaker_next = r_speaker;
      end
    end
  end

  always_comb begin
    w_burst_next = r_burst;
    if (w_enter && ((w_state_next == ST_RING_ON) || (w_state_next == ST_BUZZ_ON))) begin
      if (r_state == ST_IDLE) begin
        w_burst_next = 8'd1;
      end else if (r_burst != BURST_MAX) begin
        w_burst_next = r_burst + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_speaker <= 1'b0;
      r_burst   <= 8'd0;
    end else begin
      r_speaker <= w_speaker_next;
      r_burst   <= w_burst_next;
    end
  end

  assign speaker     = r_speaker;
  assign motor       = (r_state == ST_BUZZ_ON);
  assign active      = (r_state != ST_IDLE);
  assign burst_count = r_burst;

endmodule

// File: tb/tb_ringer_cadence_driver.sv
// ---------------------------------------------------------------------------
// tb_ringer_cadence_driver
// Two instances share the stimulus: u0 with default timing, u1 with every
// duration at 1 (fast saturation). A cadence model works from "mode" and
// "cycles since mode entry" arithmetic and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_ringer_cadence_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic ring;
  logic mot;

  logic       spk0, mot0, act0;
  logic [7:0] bc0;
  logic       spk1, mot1, act1;
  logic [7:0] bc1;

  int n_checks = 0;
  int n_errors = 0;

  ringer_cadence_driver u0 (
    .clk            (clk),
    .reset          (reset),
    .turn_on_ringer (ring),
    .turn_on_motor  (mot),
    .speaker        (spk0),
    .motor          (mot0),
    .active         (act0),
    .burst_count    (bc0)
  );

  ringer_cadence_driver #(
    .RING_ON_CYCLES  (1),
    .RING_OFF_CYCLES (1),
    .BUZZ_ON_CYCLES  (1),
    .BUZZ_OFF_CYCLES (1),
    .TONE_HALF       (1)
  ) u1 (
    .clk            (clk),
    .reset          (reset),
    .turn_on_ringer (ring),
    .turn_on_motor  (mot),
    .speaker        (spk1),
    .motor          (mot1),
    .active         (act1),
    .burst_count    (bc1)
  );

  // Per-instance timing, index 0 = u0, 1 = u1.
  int p_ron[2]  = '{8, 1};
  int p_roff[2] = '{16, 1};
  int p_bon[2]  = '{4, 1};
  int p_boff[2] = '{4, 1};
  int p_th[2]   = '{2, 1};

  // Model: mode 0 idle, 1 ring, 2 buzz; k = cycles since mode entry.
  int m_mode[2];
  int m_k[2];
  int m_cnt[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int m_pos(input int i);
    int period;
    period = (m_mode[i] == 1) ? (p_ron[i] + p_roff[i]) : (p_bon[i] + p_boff[i]);
    return m_k[i] % period;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0;
      m_k[i]    = 0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_step(input int i, input logic r, input logic m);
    int nm;
    nm = r ? 1 : (m ? 2 : 0);
    if (nm == 0) begin
      m_mode[i] = 0;
    end else if (nm != m_mode[i]) begin
      m_cnt[i]  = (m_mode[i] == 0) ? 1 : sat255(m_cnt[i] + 1);
      m_mode[i] = nm;
      m_k[i]    = 0;
    end else begin
      m_k[i]++;
      if (m_pos(i) == 0) m_cnt[i] = sat255(m_cnt[i] + 1);
    end
  endtask

  task automatic check_dut(input int i, input string what);
    logic       s, mo, a;
    logic [7:0] b;
    int         p;
    int         e_s, e_m, e_a;
    if (i == 0) begin
      s = spk0; mo = mot0; a = act0; b = bc0;
    end else begin
      s = spk1; mo = mot1; a = act1; b = bc1;
    end
    p   = (m_mode[i] == 0) ? 0 : m_pos(i);
    e_a = (m_mode[i] != 0) ? 1 : 0;
    e_m = (m_mode[i] == 2 && p < p_bon[i]) ? 1 : 0;
    e_s = (m_mode[i] == 1 && p < p_ron[i] && ((p / p_th[i]) % 2 == 0)) ? 1 : 0;
    check_eq($sformatf("%s.u%0d.speaker @%0t", what, i, $time), 32'(s), 32'(e_s));
    check_eq($sformatf("%s.u%0d.motor @%0t", what, i, $time), 32'(mo), 32'(e_m));
    check_eq($sformatf("%s.u%0d.active @%0t", what, i, $time), 32'(a), 32'(e_a));
    check_eq($sformatf("%s.u%0d.burst @%0t", what, i, $time), 32'(b), 32'(m_cnt[i]));
  endtask

  // Called at a negedge; drives, lets one posedge pass, then checks.
  task automatic tick(input logic r, input logic m, input string what);
    ring = r;
    mot  = m;
    @(posedge clk);
    model_step(0, r, m);
    model_step(1, r, m);
    @(negedge clk);
    check_dut(0, what);
    check_dut(1, what);
  endtask

  // Async reset pulse starting between edges; outputs must clear at once.
  task automatic async_reset(input string what);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_eq({what, ".speaker_now"}, 32'(spk0), 32'd0);
    check_eq({what, ".motor_now"}, 32'(mot0), 32'd0);
    check_eq({what, ".active_now"}, 32'(act0), 32'd0);
    check_eq({what, ".burst_now"}, 32'(bc0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_dut(0, what);
    check_dut(1, what);
  endtask

  initial begin
    int len;
    int sel;
    ring  = 1'b0;
    mot   = 1'b0;
    reset = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_dut(0, "por");
    check_dut(1, "por");

    for (int c = 0; c < 50; c++) tick(1'b1, 1'b0, "ring50");
    check_eq("ring50.burst_final", 32'(bc0), 32'd3);
    check_eq("ring50.in_ring_on", 32'(act0), 32'd1);

    async_reset("rst_mid_ring");
    check_eq("rst_mid_ring.burst_after", 32'(bc0), 32'd0);

    for (int c = 0; c < 20; c++) tick(1'b0, 1'b1, "motor20");
    check_eq("motor20.burst_final", 32'(bc0), 32'd3);
    tick(1'b0, 1'b0, "idle");
    tick(1'b0, 1'b0, "idle");

    for (int c = 0; c < 3; c++) tick(1'b1, 1'b0, "ring3");
    for (int c = 0; c < 6; c++) tick(1'b0, 1'b1, "to_buzz");
    check_eq("to_buzz.burst_final", 32'(bc0), 32'd2);
    tick(1'b0, 1'b0, "idle");

    for (int c = 0; c < 30; c++) tick(1'b1, 1'b1, "both");
    tick(1'b0, 1'b0, "idle");

    for (int run = 0; run < 250; run++) begin
      len = $urandom_range(1, 40);
      sel = $urandom_range(0, 3);
      for (int c = 0; c < len; c++) begin
        tick(sel[0], sel[1], "rand");
      end
      if ($urandom_range(0, 19) == 0) async_reset("rand_rst");
    end

    tick(1'b0, 1'b0, "idle");
    for (int c = 0; c < 600; c++) tick(1'b1, 1'b0, "sat");
    check_eq("sat.burst_255", 32'(bc1), 32'd255);
    tick(1'b0, 1'b0, "sat_drop");
    check_eq("sat_drop.active", 32'(act1), 32'd0);
    check_eq("sat_drop.burst_held", 32'(bc1), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
